// File: rtl/freqmeter_result_scheduler.sv
// Round-robin scheduler moving captured frequency-meter results (edge count,
// reference ticks) from per-channel requesters into the shared result memory.
`timescale 1ns/1ps
module freqmeter_result_scheduler #(
  parameter int CHANNELS = 24,
  parameter int COUNT_W  = 32,
  parameter int ADDR_W   = $clog2(CHANNELS) + 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [CHANNELS-1:0]           enable_mask_i,
  input  logic [CHANNELS-1:0]           req_i,
  input  logic [CHANNELS*COUNT_W-1:0]   ch_cycles_i,
  input  logic [CHANNELS*COUNT_W-1:0]   ch_ticks_i,
  output logic [CHANNELS-1:0]           ack_o,
  output logic                          mem_we_o,
  output logic [ADDR_W-1:0]             mem_addr_o,
  output logic [COUNT_W-1:0]            mem_data_o,
  input  logic                          mem_ready_i,
  input  logic                          irq_clr_i,
  output logic                          irq_o,
  output logic                          busy_o,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] last_ch_o
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CH_W-1:0] LAST_RESET = CH_W'(CHANNELS - 1);

  typedef enum logic [1:0] {IDLE, WR_CYC, WR_TCK, ACK} state_t;

  state_t state_r, state_nxt;

  logic [CH_W-1:0]     ch_r;
  logic [CH_W-1:0]     last_ch_r;
  logic [COUNT_W-1:0]  ticks_r;
  logic [CHANNELS-1:0] block_r;
  logic                irq_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [COUNT_W-1:0]  mem_data_r;

  logic [CHANNELS-1:0] eligible;
  logic [CHANNELS-1:0] ch_onehot;
  logic                win_found;
  logic [CH_W-1:0]     win_ch;
  logic [CH_W-1:0]     cand;
  int                  idx;

  logic [COUNT_W-1:0] cyc_arr [CHANNELS];
  logic [COUNT_W-1:0] tck_arr [CHANNELS];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_unpack
    assign cyc_arr[g] = ch_cycles_i[g*COUNT_W +: COUNT_W];
    assign tck_arr[g] = ch_ticks_i[g*COUNT_W +: COUNT_W];
  end

  assign ch_onehot = CHANNELS'(1) << ch_r;

  // Rotating priority: the search begins just past the last channel served.
  always_comb begin
    eligible  = req_i & enable_mask_i & ~block_r;
    win_found = 1'b0;
    win_ch    = '0;
    idx       = 0;
    cand      = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = int'(last_ch_r) + 1 + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      cand = CH_W'(idx);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_ch    = cand;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_r <= IDLE;
    else        state_r <= state_nxt;
  end

  always_comb begin
    state_nxt = state_r;
    mem_we_o  = 1'b0;
    ack_o     = '0;
    case (state_r)
      IDLE:   if (win_found) state_nxt = WR_CYC;
      WR_CYC: begin
        mem_we_o = 1'b1;
        if (mem_ready_i) state_nxt = WR_TCK;
      end
      WR_TCK: begin
        mem_we_o = 1'b1;
        if (mem_ready_i) state_nxt = ACK;
      end
      ACK: begin
        ack_o     = ch_onehot;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address/data are registered so they stay put through back-pressure and idle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ch_r       <= '0;
      last_ch_r  <= LAST_RESET;
      ticks_r    <= '0;
      block_r    <= '0;
      irq_r      <= 1'b0;
      mem_addr_r <= '0;
      mem_data_r <= '0;
    end else begin
      block_r <= '0;
      case (state_r)
        IDLE: if (win_found) begin
          ch_r       <= win_ch;
          ticks_r    <= tck_arr[win_ch];
          mem_addr_r <= {win_ch, 1'b0};
          mem_data_r <= cyc_arr[win_ch];
        end
        WR_CYC: if (mem_ready_i) begin
          mem_addr_r <= {ch_r, 1'b1};
          mem_data_r <= ticks_r;
        end
        ACK: begin
          last_ch_r <= ch_r;
          block_r   <= ch_onehot;
        end
        default: ;
      endcase
      if (state_r == ACK) irq_r <= 1'b1;
      else if (irq_clr_i) irq_r <= 1'b0;
    end
  end

  assign mem_addr_o = mem_addr_r;
  assign mem_data_o = mem_data_r;
  assign irq_o      = irq_r;
  assign busy_o     = (state_r != IDLE);
  assign last_ch_o  = last_ch_r;

endmodule

// File: tb/tb_freqmeter_result_scheduler.sv
// Scoreboard bench: directed requests push expected memory writes and acks,
// a negedge monitor pops and compares whatever the scheduler emits.
`timescale 1ns/1ps
module tb_freqmeter_result_scheduler;

  localparam int CHANNELS = 24;
  localparam int COUNT_W  = 32;
  localparam int ADDR_W   = 6;
  localparam int CH_W     = 5;

  logic                        clk_i = 1'b0;
  logic                        rst_i = 1'b0;
  logic [CHANNELS-1:0]         enable_mask_i = '1;
  logic [CHANNELS-1:0]         req_i = '0;
  logic [CHANNELS*COUNT_W-1:0] ch_cycles_i;
  logic [CHANNELS*COUNT_W-1:0] ch_ticks_i;
  logic [CHANNELS-1:0]         ack_o;
  logic                        mem_we_o;
  logic [ADDR_W-1:0]           mem_addr_o;
  logic [COUNT_W-1:0]          mem_data_o;
  logic                        mem_ready_i = 1'b1;
  logic                        irq_clr_i = 1'b0;
  logic                        irq_o;
  logic                        busy_o;
  logic [CH_W-1:0]             last_ch_o;

  logic [COUNT_W-1:0] cyc_tab [CHANNELS];
  logic [COUNT_W-1:0] tck_tab [CHANNELS];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
    assign ch_cycles_i[g*COUNT_W +: COUNT_W] = cyc_tab[g];
    assign ch_ticks_i[g*COUNT_W +: COUNT_W]  = tck_tab[g];
  end

  int checks = 0;
  int errors = 0;

  logic [ADDR_W+COUNT_W-1:0] wr_q [$];
  logic [CH_W-1:0]           ack_q [$];

  freqmeter_result_scheduler #(
    .CHANNELS(CHANNELS), .COUNT_W(COUNT_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_mask_i(enable_mask_i), .req_i(req_i),
    .ch_cycles_i(ch_cycles_i), .ch_ticks_i(ch_ticks_i), .ack_o(ack_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_ready_i(mem_ready_i), .irq_clr_i(irq_clr_i), .irq_o(irq_o),
    .busy_o(busy_o), .last_ch_o(last_ch_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_counts(input logic [CH_W-1:0] ch, input logic [COUNT_W-1:0] c,
                            input logic [COUNT_W-1:0] t);
    cyc_tab[ch] = c;
    tck_tab[ch] = t;
  endtask

  task automatic push_txn(input logic [CH_W-1:0] ch, input logic [COUNT_W-1:0] c,
                          input logic [COUNT_W-1:0] t);
    wr_q.push_back({ch, 1'b0, c});
    wr_q.push_back({ch, 1'b1, t});
    ack_q.push_back(ch);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Waits for the ack of ch; lat counts cycles from the call to the ack cycle.
  task automatic wait_ack(input logic [CH_W-1:0] ch, input int budget, input bit clr_in_ack,
                          input bit drop_now, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (ack_o != '0) begin
        check($sformatf("ack_ch%0d", ch), 64'(ack_o), 64'(CHANNELS'(1) << ch));
        if (drop_now) req_i[ch] = 1'b0;
        if (clr_in_ack) irq_clr_i = 1'b1;
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL ack_timeout_ch%0d: got no ack, expected one within %0d cycles", ch, budget);
    end
  endtask

  // Monitor: every accepted write and every ack is matched against the queues.
  always @(negedge clk_i) begin
    logic [ADDR_W+COUNT_W-1:0] e;
    logic [CH_W-1:0]           a;
    if (rst_i) begin
      if (mem_we_o && mem_ready_i) begin
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_write: got addr %0d data 0x%0h, expected none",
                   mem_addr_o, mem_data_o);
        end else begin
          e = wr_q.pop_front();
          check("wr_addr", 64'(mem_addr_o), 64'(e[ADDR_W+COUNT_W-1:COUNT_W]));
          check("wr_data", 64'(mem_data_o), 64'(e[COUNT_W-1:0]));
        end
      end
      if (ack_o != '0) begin
        if (ack_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_ack: got 0x%0h, expected none", ack_o);
        end else begin
          a = ack_q.pop_front();
          check("ack_order", 64'(ack_o), 64'(CHANNELS'(1) << a));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected end before 200000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int busy_cnt;
    for (int k = 0; k < CHANNELS; k++) begin
      cyc_tab[k] = '0;
      tck_tab[k] = '0;
    end

    // Reset state
    repeat (3) step();
    check("rst_ack", 64'(ack_o), 64'h0);
    check("rst_we", 64'(mem_we_o), 64'h0);
    check("rst_addr", 64'(mem_addr_o), 64'h0);
    check("rst_data", 64'(mem_data_o), 64'h0);
    check("rst_irq", 64'(irq_o), 64'h0);
    check("rst_busy", 64'(busy_o), 64'h0);
    check("rst_last_ch", 64'(last_ch_o), 64'd23);
    rst_i = 1'b1;

    // Round-robin: 0,3,23 then re-raised 0,3 must wait for 23
    set_counts(0,  32'h1000_0000, 32'h2000_0000);
    set_counts(3,  32'h1000_0003, 32'h2000_0003);
    set_counts(23, 32'h1000_0017, 32'h2000_0017);
    push_txn(0,  32'h1000_0000, 32'h2000_0000);
    push_txn(3,  32'h1000_0003, 32'h2000_0003);
    push_txn(23, 32'h1000_0017, 32'h2000_0017);
    req_i[0] = 1'b1; req_i[3] = 1'b1; req_i[23] = 1'b1;
    wait_ack(0, 10, 1'b0, 1'b1, lat);
    check("rr_first_lat", 64'(lat), 64'd3);
    wait_ack(3, 10, 1'b0, 1'b1, lat);
    check("rr_b2b_lat", 64'(lat), 64'd4);
    set_counts(0, 32'h3000_0000, 32'h4000_0000);
    set_counts(3, 32'h3000_0003, 32'h4000_0003);
    push_txn(0, 32'h3000_0000, 32'h4000_0000);
    push_txn(3, 32'h3000_0003, 32'h4000_0003);
    req_i[0] = 1'b1; req_i[3] = 1'b1;
    wait_ack(23, 10, 1'b0, 1'b1, lat);
    check("rr_wrap_lat", 64'(lat), 64'd4);
    wait_ack(0, 10, 1'b0, 1'b1, lat);
    check("rr_second0_lat", 64'(lat), 64'd4);
    wait_ack(3, 10, 1'b0, 1'b1, lat);
    check("rr_second3_lat", 64'(lat), 64'd4);
    step();
    check("rr_last_ch", 64'(last_ch_o), 64'd3);
    check("rr_idle", 64'(busy_o), 64'h0);

    // irq clear alone, then single request with clear in ACK and late req drop
    irq_clr_i = 1'b1;
    step();
    irq_clr_i = 1'b0;
    check("irq_clr_alone", 64'(irq_o), 64'h0);
    set_counts(5, 32'h0000_1234, 32'h0000_ABCD);
    push_txn(5, 32'h0000_1234, 32'h0000_ABCD);
    req_i[5] = 1'b1;
    wait_ack(5, 10, 1'b1, 1'b0, lat);
    check("single_lat", 64'(lat), 64'd3);
    step();
    irq_clr_i = 1'b0;
    req_i[5] = 1'b0;
    check("irq_set_wins", 64'(irq_o), 64'h1);
    check("single_last_ch", 64'(last_ch_o), 64'd5);
    step();
    check("block_window", 64'(busy_o), 64'h0);

    // Back-pressure with req/mask/data changes after capture
    set_counts(9, 32'h5555_0009, 32'h0000_9999);
    push_txn(9, 32'h5555_0009, 32'h0000_9999);
    req_i[9] = 1'b1;
    mem_ready_i = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i <= 7) begin
        check($sformatf("bp_we_%0d", i), 64'(mem_we_o), 64'h1);
        check($sformatf("bp_addr_%0d", i), 64'(mem_addr_o), (i <= 4) ? 64'd18 : 64'd19);
        check($sformatf("bp_data_%0d", i), 64'(mem_data_o),
              (i <= 4) ? 64'h5555_0009 : 64'h0000_9999);
      end else begin
        check("bp_ack_n8", 64'(ack_o), 64'(CHANNELS'(1) << 9));
      end
      mem_ready_i = (i == 4 || i == 7);
      if (i == 2) begin
        req_i[9] = 1'b0;
        enable_mask_i[9] = 1'b0;
        set_counts(9, 32'hDEAD_DEAD, 32'hBEEF_BEEF);
      end
    end
    mem_ready_i = 1'b1;
    enable_mask_i[9] = 1'b1;

    // Masked channel is never served
    enable_mask_i[7] = 1'b0;
    set_counts(7, 32'h7777_7777, 32'h7777_0000);
    req_i[7] = 1'b1;
    busy_cnt = 0;
    repeat (10) begin
      step();
      if (busy_o) busy_cnt++;
    end
    check("mask_never_served", 64'(busy_cnt), 64'h0);
    req_i[7] = 1'b0;
    enable_mask_i[7] = 1'b1;

    // Reset during WR_TCK, request survives and is served afterwards
    set_counts(12, 32'h0C0C_0C0C, 32'h1212_1212);
    wr_q.push_back({5'd12, 1'b0, 32'h0C0C_0C0C});
    req_i[12] = 1'b1;
    step();
    step();
    check("rst_pre_we", 64'(mem_we_o), 64'h1);
    rst_i = 1'b0;
    #1;
    check("rst_mid_we", 64'(mem_we_o), 64'h0);
    check("rst_mid_ack", 64'(ack_o), 64'h0);
    check("rst_mid_last_ch", 64'(last_ch_o), 64'd23);
    check("rst_mid_busy", 64'(busy_o), 64'h0);
    step();
    step();
    rst_i = 1'b1;
    push_txn(12, 32'h0C0C_0C0C, 32'h1212_1212);
    wait_ack(12, 10, 1'b0, 1'b1, lat);
    check("rst_resume_lat", 64'(lat), 64'd3);
    step();
    check("rst_resume_last_ch", 64'(last_ch_o), 64'd12);

    repeat (3) step();
    check("wr_queue_drained", 64'(wr_q.size()), 64'h0);
    check("ack_queue_drained", 64'(ack_q.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/freqmeter_result_scheduler.md
# freqmeter_result_scheduler

Round-robin scheduler that moves completed measurements from up to CHANNELS frequency-meter channels into the shared result memory read by the CPU. Each Fin channel's measurement unit raises a request with a captured input-edge count and a reference-tick count. The block picks one enabled requester at a time, writes its two words into the memory through a ready-qualified write port, acknowledges the channel and raises a sticky interrupt flag. It sits between the per-channel counters and the Wishbone-visible result RAM.

## Interface
- CHANNELS, 24, number of Fin channels (1..32)
- COUNT_W, 32, width of each count word
- ADDR_W, $clog2(CHANNELS)+1, result memory word address width
- clk_i  in  1  system clock; all logic rises on posedge
- rst_i  in  1  asynchronous, active-low reset
- enable_mask_i  in  CHANNELS  per-channel service enable
- req_i  in  CHANNELS  level request: channel holds a completed measurement
- ch_cycles_i  in  CHANNELS*COUNT_W  flattened input-edge counts, channel k at [k*COUNT_W +: COUNT_W]
- ch_ticks_i  in  CHANNELS*COUNT_W  flattened reference-tick counts, same packing
- ack_o  out  CHANNELS  one-hot, one-cycle acknowledge; requester clears req on it
- mem_we_o  out  1  write strobe, held until accepted
- mem_addr_o  out  ADDR_W  {channel, word}; word 0 = cycles, 1 = ticks
- mem_data_o  out  COUNT_W  write data
- mem_ready_i  in  1  memory accepts the write on this edge when mem_we_o=1
- irq_clr_i  in  1  clears irq_o
- irq_o  out  1  sticky "new result written" flag
- busy_o  out  1  high in any state other than IDLE
- last_ch_o  out  $clog2(CHANNELS)  index of the most recently acknowledged channel

## Operation
- States: IDLE, WR_CYC, WR_TCK, ACK.
- IDLE: eligible = req_i & enable_mask_i & ~block, where block is the one-hot of the channel acknowledged in the immediately preceding ACK. It is applied only in the first IDLE cycle after ACK; it is zero otherwise. If eligible≠0: winner = first set bit searching from last_ch+1 upward with wrap to 0. On the same edge, latch winner, its cycles and its ticks into internal registers and go to WR_CYC. Otherwise stay in IDLE.
- WR_CYC: mem_we_o=1, mem_addr_o={ch,1'b0}, mem_data_o=cycles_r. On mem_ready_i go to WR_TCK.
- WR_TCK: mem_we_o=1, mem_addr_o={ch,1'b1}, mem_data_o=ticks_r. On mem_ready_i go to ACK.
- ACK: ack_o[ch]=1 for exactly this cycle. last_ch←ch, irq_o←1, block←onehot(ch). Go to IDLE.
- Captured data is used throughout the transaction. Changes to req_i, enable_mask_i or the count inputs after capture do not affect the transaction in progress.
- Clearing a channel's mask bit while that channel is being served does not abort the transaction; it completes normally.
- irq_o: set in ACK, cleared by irq_clr_i. If set and clear occur in the same cycle, set wins.
- mem_addr_o and mem_data_o outside the write states: hold their last values; they are don't-care when mem_we_o=0.

## Timing
- Reset (rst_i=0, asynchronous): state←IDLE and last_ch←CHANNELS-1, so channel 0 has first priority. All outputs are 0 (ack_o, mem_we_o, mem_addr_o, mem_data_o, irq_o, busy_o, last_ch_o reset to CHANNELS-1 internally, output shows that value). block←0.
- Reset mid-transaction: mem_we_o drops immediately and no ack is issued. The channel's request remains pending and is served after reset releases.
- With mem_ready_i held at 1, a request sampled at edge N produces:
  - WR_CYC during cycle N+1, WR_TCK during N+2, ack_o during N+3.
  - Back in IDLE at N+4; the next winner can be sampled at edge N+4.
  - Minimum service: 4 cycles per channel.
- Each cycle with mem_ready_i=0 in WR_CYC or WR_TCK adds one cycle. Address, data and we are stable throughout the wait.
- The requester must drop req_i by the edge after ack_o deasserts; the block window covers exactly that edge.

## Test plan
- Single request: mask=all-ones, req_i[5]=1, cycles=0x1234, ticks=0xABCD, mem_ready_i=1 → writes (addr 10, 0x1234) then (addr 11, 0xABCD); ack_o=1<<5 at N+3; irq_o=1; last_ch_o=5.
- Round-robin: req_i[0], req_i[3] and req_i[23] held (requester clears each on its ack) → service order 0, 3, 23. Re-raising req_i[0] and req_i[3] with last_ch=3 → order 0 before 3 only after 23 wraps; check the search starts at last_ch+1.
- Back-pressure: mem_ready_i=0 for 3 cycles in WR_CYC and 2 cycles in WR_TCK → addr and data stable throughout; ack arrives at N+8.
- Mask and data changes: mask bit 7 clear with req_i[7]=1 → never served. Dropping req_i and changing ch_cycles_i mid-transaction → originally captured values are written.
- irq handling: irq_clr_i pulsed in the same cycle as ACK → irq_o stays 1; irq_clr_i alone → irq_o=0 on the next cycle.
- Reset: assert rst_i=0 during WR_TCK → mem_we_o=0 immediately, no ack, last_ch_o=CHANNELS-1. After release, the still-pending channel is served from WR_CYC.
